// File: rtl/ex_stage_pkg.sv
// Shared opcodes, result classes, divider state codes and small helpers
// for the execute stage and its divider.
package ex_stage_pkg;

    localparam int unsigned ALU_OP_W  = 8;
    localparam int unsigned ALU_SEL_W = 3;
    localparam int unsigned REG_W     = 32;
    localparam int unsigned REG_AW    = 5;
    localparam int unsigned SHAMT_W   = 5;

    localparam logic [ALU_OP_W-1:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [ALU_OP_W-1:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [ALU_OP_W-1:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [ALU_OP_W-1:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [ALU_OP_W-1:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [ALU_OP_W-1:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [ALU_OP_W-1:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [ALU_OP_W-1:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [ALU_OP_W-1:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [ALU_OP_W-1:0] EXE_DIVU_OP = 8'b0001_1011;

    localparam logic [ALU_SEL_W-1:0] EXE_RES_NOP   = 3'b000;
    localparam logic [ALU_SEL_W-1:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [ALU_SEL_W-1:0] EXE_RES_SHIFT = 3'b010;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    // Two's-complement negate when en is set, pass-through otherwise.
    function automatic logic [REG_W-1:0] twos_neg(input logic [REG_W-1:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Decode-to-execute operand bundle plus the execute results and stall request.
interface ex_stage_if;
    import ex_stage_pkg::*;

    logic                  flush_i;
    logic [ALU_OP_W-1:0]   aluop_i;
    logic [ALU_SEL_W-1:0]  alusel_i;
    logic [REG_W-1:0]      reg1_i;
    logic [REG_W-1:0]      reg2_i;
    logic [REG_AW-1:0]     wd_i;
    logic                  wreg_i;
    logic [REG_AW-1:0]     wd_o;
    logic                  wreg_o;
    logic [REG_W-1:0]      wdata_o;
    logic                  whilo_o;
    logic [REG_W-1:0]      hi_o;
    logic [REG_W-1:0]      lo_o;
    logic                  stallreq_o;

    modport master (
        output flush_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
        input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );

    modport slave (
        input  flush_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
        output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );

endinterface

// File: rtl/ex_stage_div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle, sign
// fix-up applied as the final step lands, result held until the next divide.
module div_unit
    import ex_stage_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic [REG_W-1:0]     op1,
    input  logic [REG_W-1:0]     op2,
    input  logic                 annul,
    output logic                 ready,
    output logic [2*REG_W-1:0]   result
);

    localparam int unsigned       CNT_W    = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV_CYCLES - 1);

    div_state_t            state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [2*REG_W:0]      work_r;
    logic [REG_W-1:0]      divisor_r;
    logic                  neg_quot_r;
    logic                  neg_rem_r;
    logic                  ready_r;
    logic [2*REG_W-1:0]    result_r;

    logic [REG_W:0]        partial_s;
    logic [REG_W-1:0]      diff_s;
    logic [REG_W-1:0]      abs1_s;
    logic [REG_W-1:0]      abs2_s;
    logic [REG_W-1:0]      quot_s;
    logic [REG_W-1:0]      rem_s;
    logic [2*REG_W:0]      step_s;

    // Operand magnitudes, one restoring-subtract step and the signed fix-up
    always_comb begin
        abs1_s    = twos_neg(op1, signed_div & op1[REG_W-1]);
        abs2_s    = twos_neg(op2, signed_div & op2[REG_W-1]);
        partial_s = work_r[2*REG_W:REG_W];
        // Only the low word matters: a successful subtract leaves less than the divisor.
        diff_s    = partial_s[REG_W-1:0] - divisor_r;
        if (partial_s >= {1'b0, divisor_r}) begin
            step_s = {diff_s, work_r[REG_W-1:0], 1'b1};
        end else begin
            step_s = {work_r[2*REG_W-1:0], 1'b0};
        end
        quot_s = twos_neg(step_s[REG_W-1:0], neg_quot_r);
        rem_s  = twos_neg(step_s[2*REG_W:REG_W+1], neg_rem_r);
    end

    // Divider FSM: IDLE -> ON (or BY_ZERO) -> END, annul returns to IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= DivFree;
            cnt_r      <= CNT_W'(0);
            work_r     <= 65'd0;
            divisor_r  <= 32'd0;
            neg_quot_r <= 1'b0;
            neg_rem_r  <= 1'b0;
            ready_r    <= 1'b0;
            result_r   <= 64'd0;
        end else begin
            ready_r <= 1'b0;
            case (state_r)
                DivFree: begin
                    if (annul || !start) begin
                        state_r <= DivFree;
                    end else if (op2 == 32'd0) begin
                        state_r <= DivByZero;
                    end else begin
                        work_r     <= {32'd0, abs1_s, 1'b0};
                        divisor_r  <= abs2_s;
                        neg_quot_r <= signed_div & (op1[REG_W-1] ^ op2[REG_W-1]);
                        neg_rem_r  <= signed_div & op1[REG_W-1];
                        cnt_r      <= CNT_W'(0);
                        state_r    <= DivOn;
                    end
                end
                DivByZero: begin
                    if (annul) begin
                        state_r <= DivFree;
                    end else begin
                        result_r <= 64'd0;
                        ready_r  <= 1'b1;
                        state_r  <= DivEnd;
                    end
                end
                DivOn: begin
                    // A non-divide op here only follows a flush; drop the partial result.
                    if (annul || !start) begin
                        state_r <= DivFree;
                    end else begin
                        work_r <= step_s;
                        if (cnt_r == CNT_LAST) begin
                            result_r <= {rem_s, quot_s};
                            ready_r  <= 1'b1;
                            cnt_r    <= CNT_W'(0);
                            state_r  <= DivEnd;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                DivEnd: begin
                    state_r <= DivFree;
                end
                default: begin
                    state_r <= DivFree;
                end
            endcase
        end
    end

    assign ready  = ready_r;
    assign result = result_r;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift results for write-back and forwarding,
// plus HI/LO write from the multi-cycle divider with a pipeline stall request.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    ex_stage_if.slave   ex
);

    logic                  is_div_s;
    logic                  is_signed_s;
    logic                  div_ready_s;
    logic [2*REG_W-1:0]    div_result_s;
    logic [REG_W-1:0]      logic_res_s;
    logic [REG_W-1:0]      shift_res_s;
    logic [REG_W-1:0]      wdata_s;
    logic [SHAMT_W-1:0]    shamt_s;

    assign is_div_s    = (ex.aluop_i == EXE_DIV_OP) || (ex.aluop_i == EXE_DIVU_OP);
    assign is_signed_s = (ex.aluop_i == EXE_DIV_OP);
    assign shamt_s     = ex.reg1_i[SHAMT_W-1:0];

    // Bitwise logic result
    always_comb begin
        logic_res_s = 32'd0;
        case (ex.aluop_i)
            EXE_OR_OP:  logic_res_s = ex.reg1_i | ex.reg2_i;
            EXE_AND_OP: logic_res_s = ex.reg1_i & ex.reg2_i;
            EXE_XOR_OP: logic_res_s = ex.reg1_i ^ ex.reg2_i;
            EXE_NOR_OP: logic_res_s = ~(ex.reg1_i | ex.reg2_i);
            default:    logic_res_s = 32'd0;
        endcase
    end

    // Shift result: reg2 shifted by reg1[4:0]
    always_comb begin
        shift_res_s = 32'd0;
        case (ex.aluop_i)
            EXE_SLL_OP: shift_res_s = ex.reg2_i << shamt_s;
            EXE_SRL_OP: shift_res_s = ex.reg2_i >> shamt_s;
            EXE_SRA_OP: shift_res_s = $unsigned($signed(ex.reg2_i) >>> shamt_s);
            default:    shift_res_s = 32'd0;
        endcase
    end

    // Write-back data selected by result class
    always_comb begin
        wdata_s = 32'd0;
        case (ex.alusel_i)
            EXE_RES_LOGIC: wdata_s = logic_res_s;
            EXE_RES_SHIFT: wdata_s = shift_res_s;
            default:       wdata_s = 32'd0;
        endcase
    end

    div_unit #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start      (is_div_s),
        .signed_div (is_signed_s),
        .op1        (ex.reg1_i),
        .op2        (ex.reg2_i),
        .annul      (ex.flush_i),
        .ready      (div_ready_s),
        .result     (div_result_s)
    );

    // Forwarding paths stay combinational; everything reads zero while reset is held.
    assign ex.wd_o       = rst ? 5'd0  : ex.wd_i;
    assign ex.wreg_o     = rst ? 1'b0  : ex.wreg_i;
    assign ex.wdata_o    = rst ? 32'd0 : wdata_s;
    assign ex.hi_o       = rst ? 32'd0 : div_result_s[2*REG_W-1:REG_W];
    assign ex.lo_o       = rst ? 32'd0 : div_result_s[REG_W-1:0];
    assign ex.whilo_o    = ~rst & div_ready_s & ~ex.flush_i;
    assign ex.stallreq_o = ~rst & is_div_s & ~div_ready_s;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: drivers push expected results, a negedge
// monitor pops and compares whenever an ALU result or HI/LO strobe appears.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    ex_stage_if bus ();

    ex_stage #(.DIV_CYCLES(32)) dut (
        .clk (clk),
        .rst (rst),
        .ex  (bus)
    );

    always #5 clk = ~clk;

    typedef struct { string name; logic [4:0] wd; logic wreg; logic [31:0] wdata; } alu_exp_t;
    typedef struct { string name; logic [31:0] hi; logic [31:0] lo; } div_exp_t;

    alu_exp_t alu_q[$];
    div_exp_t div_q[$];
    logic     alu_valid = 1'b0;
    int       n_checks  = 0;
    int       n_fail    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush_i  = 1'b0;
        bus.aluop_i  = EXE_NOP_OP;
        bus.alusel_i = EXE_RES_NOP;
        bus.reg1_i   = 32'd0;
        bus.reg2_i   = 32'd0;
        bus.wd_i     = 5'd0;
        bus.wreg_i   = 1'b0;
    endtask

    // Monitor: compare every presented ALU result and every HI/LO strobe
    always @(negedge clk) begin
        alu_exp_t ae;
        div_exp_t de;
        if (alu_valid) begin
            n_checks++;
            if (alu_q.size() == 0) begin
                n_fail++;
                $display("FAIL alu_scoreboard: got an ALU result, expected none queued");
            end else begin
                ae = alu_q.pop_front();
                check({ae.name, "_wdata"}, bus.wdata_o, ae.wdata);
                check({ae.name, "_wd"}, {27'd0, bus.wd_o}, {27'd0, ae.wd});
                check({ae.name, "_wreg"}, {31'd0, bus.wreg_o}, {31'd0, ae.wreg});
                check({ae.name, "_stall"}, {31'd0, bus.stallreq_o}, 32'd0);
            end
        end
        if (bus.whilo_o === 1'b1) begin
            n_checks++;
            if (div_q.size() == 0) begin
                n_fail++;
                $display("FAIL whilo_scoreboard: got whilo_o=1, expected 0 (no divide pending)");
            end else begin
                de = div_q.pop_front();
                check({de.name, "_hi"}, bus.hi_o, de.hi);
                check({de.name, "_lo"}, bus.lo_o, de.lo);
                check({de.name, "_stall_at_whilo"}, {31'd0, bus.stallreq_o}, 32'd0);
            end
        end
    end

    task automatic alu(input string name, input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [4:0] wd, input logic wreg, input logic [31:0] exp);
        alu_q.push_back('{name, wd, wreg, exp});
        bus.aluop_i  = op;
        bus.alusel_i = sel;
        bus.reg1_i   = r1;
        bus.reg2_i   = r2;
        bus.wd_i     = wd;
        bus.wreg_i   = wreg;
        alu_valid    = 1'b1;
        tick();
        alu_valid    = 1'b0;
        idle_inputs();
    endtask

    // Issue a divide, hold it while stalled, and count the stall cycles.
    task automatic div(input string name, input bit sgn, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo, input int exp_stalls);
        int stalls;
        bit done;
        stalls = 0;
        done   = 1'b0;
        div_q.push_back('{name, exp_hi, exp_lo});
        bus.flush_i  = 1'b0;
        bus.aluop_i  = sgn ? EXE_DIV_OP : EXE_DIVU_OP;
        bus.alusel_i = EXE_RES_NOP;
        bus.reg1_i   = r1;
        bus.reg2_i   = r2;
        bus.wd_i     = 5'd0;
        bus.wreg_i   = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (bus.stallreq_o) begin
                stalls++;
            end else begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got stall after 60 cycles, expected release", name);
        end
        check({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
        tick();
        idle_inputs();
    endtask

    // Start DIVU 100/7, kill it at ON cnt=at_cnt via flush or rst, then DIVU 9/3.
    task automatic abort_div(input string name, input bit use_rst, input int at_cnt);
        bus.aluop_i  = EXE_DIVU_OP;
        bus.alusel_i = EXE_RES_NOP;
        bus.reg1_i   = 32'd100;
        bus.reg2_i   = 32'd7;
        repeat (at_cnt + 1) tick();
        if (use_rst) begin
            rst = 1'b1;
        end else begin
            bus.flush_i = 1'b1;
        end
        @(negedge clk);
        if (use_rst) begin
            check({name, "_rst_stall"}, {31'd0, bus.stallreq_o}, 32'd0);
            check({name, "_rst_hi"}, bus.hi_o, 32'd0);
            check({name, "_rst_lo"}, bus.lo_o, 32'd0);
        end else begin
            check({name, "_flush_stall"}, {31'd0, bus.stallreq_o}, 32'd1);
        end
        check({name, "_whilo"}, {31'd0, bus.whilo_o}, 32'd0);
        tick();
        rst = 1'b0;
        idle_inputs();
        div({name, "_divu_9_3"}, 1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 33);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        bus.aluop_i  = EXE_OR_OP;
        bus.alusel_i = EXE_RES_LOGIC;
        bus.reg1_i   = 32'h0000_F0F0;
        bus.reg2_i   = 32'h00FF_00FF;
        bus.wd_i     = 5'd7;
        bus.wreg_i   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_wd", {27'd0, bus.wd_o}, 32'd0);
        check("reset_wreg", {31'd0, bus.wreg_o}, 32'd0);
        check("reset_wdata", bus.wdata_o, 32'd0);
        check("reset_whilo", {31'd0, bus.whilo_o}, 32'd0);
        check("reset_hi", bus.hi_o, 32'd0);
        check("reset_lo", bus.lo_o, 32'd0);
        check("reset_stall", {31'd0, bus.stallreq_o}, 32'd0);
        tick();
        rst = 1'b0;
        idle_inputs();

        alu("or",  EXE_OR_OP,  EXE_RES_LOGIC, 32'h0000_F0F0, 32'h00FF_00FF, 5'd5,  1'b1, 32'h00FF_F0FF);
        alu("and", EXE_AND_OP, EXE_RES_LOGIC, 32'h0000_F0F0, 32'h00FF_00FF, 5'd9,  1'b1, 32'h0000_00F0);
        alu("xor", EXE_XOR_OP, EXE_RES_LOGIC, 32'h0000_F0F0, 32'h00FF_00FF, 5'd31, 1'b0, 32'h00FF_F00F);
        alu("nor", EXE_NOR_OP, EXE_RES_LOGIC, 32'h0000_F0F0, 32'h00FF_00FF, 5'd1,  1'b1, 32'hFF00_0F00);
        alu("sra", EXE_SRA_OP, EXE_RES_SHIFT, 32'd4,         32'h8000_0000, 5'd2,  1'b1, 32'hF800_0000);
        alu("srl", EXE_SRL_OP, EXE_RES_SHIFT, 32'd4,         32'h8000_0000, 5'd3,  1'b1, 32'h0800_0000);
        alu("sll", EXE_SLL_OP, EXE_RES_SHIFT, 32'd31,        32'h0000_0001, 5'd4,  1'b1, 32'h8000_0000);
        alu("sra_zero", EXE_SRA_OP, EXE_RES_SHIFT, 32'd0,    32'h8000_0001, 5'd6,  1'b1, 32'h8000_0001);
        alu("sra_pos",  EXE_SRA_OP, EXE_RES_SHIFT, 32'd31,   32'h7FFF_FFFF, 5'd6,  1'b1, 32'h0000_0000);
        alu("srl_hi_bits", EXE_SRL_OP, EXE_RES_SHIFT, 32'hFFFF_FFE4, 32'h8000_0000, 5'd8, 1'b1, 32'h0800_0000);
        alu("unknown_op", 8'h55, EXE_RES_LOGIC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 1'b1, 32'h0000_0000);
        alu("res_nop", EXE_OR_OP, EXE_RES_NOP, 32'hFFFF_FFFF, 32'h1234_5678, 5'd11, 1'b1, 32'h0000_0000);

        div("divu_100_7",   1'b0, 32'd100,       32'd7,         32'd2,         32'd14,        33);
        div("div_m7_2",     1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        div("div_min_m1",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33);
        div("div_7_m2",     1'b1, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33);
        div("divu_big",     1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'd1,         33);
        div("div_by_zero",  1'b1, 32'd5,         32'd0,         32'd0,         32'd0,         2);
        div("divu_after_0", 1'b0, 32'd9,         32'd3,         32'd0,         32'd3,         33);

        abort_div("flush_cnt10", 1'b0, 10);
        abort_div("rst_cnt20",   1'b1, 20);

        alu("or_after_div", EXE_OR_OP, EXE_RES_LOGIC, 32'h1000_0000, 32'h0000_0001, 5'd12, 1'b1, 32'h1000_0001);
        repeat (3) tick();

        n_checks++;
        if ((alu_q.size() != 0) || (div_q.size() != 0)) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d alu / %0d div entries left, expected 0 / 0",
                     alu_q.size(), div_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running at 1 ms, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
